// File: rtl/i2c_slave_ctrl.sv
// Sequencing controller for an I2C slave transmitter: address ACK decision, shift enables,
// TX FIFO pop and SDA output-mode select, driven by timer and bus-condition strobes.
module i2c_slave_ctrl (
  input  logic       clk,
  input  logic       rst,
  input  logic       start_found,
  input  logic       stop_found,
  input  logic       byte_received,
  input  logic       ack_prep,
  input  logic       check_ack,
  input  logic       ack_done,
  input  logic       rw_mode,
  input  logic       address_match,
  input  logic       sda_in,
  input  logic       tx_fifo_empty,
  output logic       rx_enable,
  output logic       tx_enable,
  output logic       load_data,
  output logic       read_enable,
  output logic [1:0] sda_mode,
  output logic       underrun,
  output logic [7:0] bytes_sent
);

  typedef enum logic [3:0] {
    StIdle     = 4'd0,
    StAddr     = 4'd1,
    StDecide   = 4'd2,
    StAckAddr  = 4'd3,
    StNackAddr = 4'd4,
    StLoad     = 4'd5,
    StTx       = 4'd6,
    StWaitAck  = 4'd7,
    StAcked    = 4'd8,
    StWaitStop = 4'd9
  } state_e;

  state_e     state_q, state_d;
  logic       underrun_q, underrun_d;
  logic [7:0] bytes_sent_q, bytes_sent_d;

  // The ACK window opening needs no action: sda_mode is already set by the state.
  logic unused_ack_prep;
  assign unused_ack_prep = ack_prep;

  always_comb begin
    state_d = state_q;
    if (state_q == StIdle) begin
      if (start_found) state_d = StAddr;
    end else if (stop_found) begin
      state_d = StIdle;
    end else if (start_found) begin
      state_d = StAddr;
    end else begin
      case (state_q)
        StAddr:     if (byte_received) state_d = StDecide;
        StDecide:   state_d = (address_match && rw_mode) ? StAckAddr : StNackAddr;
        StAckAddr:  if (ack_done) state_d = StLoad;
        StNackAddr: if (ack_done) state_d = StIdle;
        StLoad:     state_d = StTx;
        StTx:       if (byte_received) state_d = StWaitAck;
        StWaitAck:  if (check_ack) state_d = sda_in ? StWaitStop : StAcked;
        StAcked:    if (ack_done) state_d = StLoad;
        StWaitStop: state_d = StWaitStop;
        default:    state_d = StIdle;
      endcase
    end
  end

  always_comb begin
    bytes_sent_d = bytes_sent_q;
    if (state_d == StAddr) begin
      bytes_sent_d = 8'd0;
    end else if (state_q == StWaitAck && state_d == StAcked) begin
      bytes_sent_d = bytes_sent_q + 8'd1;
    end
    underrun_d = underrun_q | (state_q == StLoad && tx_fifo_empty);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      underrun_q   <= 1'b0;
      bytes_sent_q <= 8'd0;
    end else begin
      state_q      <= state_d;
      underrun_q   <= underrun_d;
      bytes_sent_q <= bytes_sent_d;
    end
  end

  // Outputs decode from state_q only, so an asynchronous reset releases SDA immediately.
  always_comb begin
    rx_enable   = 1'b0;
    tx_enable   = 1'b0;
    load_data   = 1'b0;
    read_enable = 1'b0;
    sda_mode    = 2'd0;
    case (state_q)
      StAddr:     rx_enable = 1'b1;
      StAckAddr:  sda_mode = 2'd1;
      StNackAddr: sda_mode = 2'd2;
      StLoad: begin
        load_data   = 1'b1;
        read_enable = !tx_fifo_empty;
      end
      StTx: begin
        tx_enable = 1'b1;
        sda_mode  = 2'd3;
      end
      default: ;
    endcase
  end

  assign underrun   = underrun_q;
  assign bytes_sent = bytes_sent_q;

endmodule

// File: tb/tb_i2c_slave_ctrl.sv
// Randomized scoreboard bench for i2c_slave_ctrl: transaction-level model predicts load pulses,
// address ACK decisions, byte counts and the sticky underrun flag.
module tb_i2c_slave_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start_found = 1'b0, stop_found = 1'b0, byte_received = 1'b0, ack_prep = 1'b0;
  logic       check_ack = 1'b0, ack_done = 1'b0, rw_mode = 1'b0, address_match = 1'b0;
  logic       sda_in = 1'b1, tx_fifo_empty = 1'b0;
  logic       rx_enable, tx_enable, load_data, read_enable, underrun;
  logic [1:0] sda_mode;
  logic [7:0] bytes_sent;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic       rd;
    logic [7:0] cnt;
  } load_exp_t;

  load_exp_t load_q[$];
  int        ack_q[$];

  logic [7:0] model_cnt = 8'd0;
  logic       model_unr = 1'b0;

  i2c_slave_ctrl dut (
    .clk           (clk),
    .rst           (rst),
    .start_found   (start_found),
    .stop_found    (stop_found),
    .byte_received (byte_received),
    .ack_prep      (ack_prep),
    .check_ack     (check_ack),
    .ack_done      (ack_done),
    .rw_mode       (rw_mode),
    .address_match (address_match),
    .sda_in        (sda_in),
    .tx_fifo_empty (tx_fifo_empty),
    .rx_enable     (rx_enable),
    .tx_enable     (tx_enable),
    .load_data     (load_data),
    .read_enable   (read_enable),
    .sda_mode      (sda_mode),
    .underrun      (underrun),
    .bytes_sent    (bytes_sent)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    start_found   = 1'b0;
    stop_found    = 1'b0;
    byte_received = 1'b0;
    ack_prep      = 1'b0;
    check_ack     = 1'b0;
    ack_done      = 1'b0;
  endtask

  task automatic gap();
    repeat ($urandom_range(0, 2)) tick();
  endtask

  task automatic check_quiet(input string name);
    check(name, int'({rx_enable, tx_enable, load_data, read_enable, sda_mode}), 0);
  endtask

  // Monitor: consumes expectations whenever the DUT presents a load pulse or an address ACK/NACK.
  logic       prev_load = 1'b0;
  logic [1:0] prev_mode = 2'd0;
  always @(negedge clk) begin
    load_exp_t e;
    if (rst) begin
      prev_load = 1'b0;
      prev_mode = 2'd0;
    end else begin
      if (load_data) begin
        check("load_expected", int'(load_q.size() > 0), 1);
        if (load_q.size() > 0) begin
          e = load_q.pop_front();
          check("load_read_enable", int'(read_enable), int'(e.rd));
          check("load_bytes_sent", int'(bytes_sent), int'(e.cnt));
        end
      end
      if (prev_load) begin
        check("post_load_tx_enable", int'(tx_enable), 1);
        check("post_load_sda_mode", int'(sda_mode), 3);
      end
      if ((sda_mode == 2'd1 || sda_mode == 2'd2) && !(prev_mode == 2'd1 || prev_mode == 2'd2)) begin
        check("addr_ack_expected", int'(ack_q.size() > 0), 1);
        if (ack_q.size() > 0) check("addr_ack_mode", int'(sda_mode), ack_q.pop_front());
      end
      prev_load = load_data;
      prev_mode = sda_mode;
    end
  end

  task automatic transfer();
    logic am, rw, empty, last;
    int   nbytes, ending, abort_at, exp_mode;
    start_found = 1'b1;
    tick();
    model_cnt = 8'd0;
    check("addr_rx_enable", int'(rx_enable), 1);
    check("addr_bytes_cleared", int'(bytes_sent), 0);
    gap();
    am = ($urandom_range(0, 3) != 0);
    rw = ($urandom_range(0, 3) != 0);
    exp_mode = (am && rw) ? 1 : 2;
    address_match = am;
    rw_mode = rw;
    byte_received = 1'b1;
    ack_q.push_back(exp_mode);
    tick();
    check_quiet("decide_quiet");
    tick();
    gap();
    ack_prep = 1'b1;
    tick();
    check_ack = 1'b1;
    sda_in = 1'b0;
    tick();
    gap();
    check("addr_mode_hold", int'(sda_mode), exp_mode);
    if (exp_mode == 2) begin
      ack_done = 1'b1;
      tick();
      check_quiet("nack_idle");
      stop_found = $urandom_range(0, 1) == 1;
      tick();
      check("nack_bytes_sent", int'(bytes_sent), 0);
      return;
    end
    nbytes   = $urandom_range(1, 4);
    ending   = $urandom_range(0, 4);
    abort_at = $urandom_range(1, nbytes);
    for (int b = 1; b <= nbytes; b++) begin
      empty = ($urandom_range(0, 3) == 0);
      tx_fifo_empty = empty;
      ack_done = 1'b1;
      load_q.push_back('{rd: !empty, cnt: model_cnt});
      model_unr = model_unr | empty;
      tick();
      tick();
      gap();
      if (ending >= 2 && b == abort_at) begin
        if (ending != 4) stop_found = 1'b1;
        if (ending != 2) start_found = 1'b1;
        tick();
        if (ending == 4) begin
          model_cnt = 8'd0;
          check("restart_rx_enable", int'(rx_enable), 1);
        end else begin
          check_quiet("abort_idle");
        end
        check("abort_bytes_sent", int'(bytes_sent), int'(model_cnt));
        return;
      end
      byte_received = 1'b1;
      tick();
      gap();
      check("wait_ack_mode", int'({tx_enable, sda_mode}), 0);
      last = (b == nbytes);
      sda_in = last;
      check_ack = 1'b1;
      tick();
      if (!last) model_cnt = model_cnt + 8'd1;
      check("ack_bytes_sent", int'(bytes_sent), int'(model_cnt));
      gap();
      if (last) begin
        check_quiet("wait_stop_quiet");
        if (ending != 1) begin
          stop_found = 1'b1;
          tick();
          check_quiet("stop_idle");
          check("stop_bytes_hold", int'(bytes_sent), int'(model_cnt));
        end
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check_quiet("reset_outputs");
    check("reset_bytes_sent", int'(bytes_sent), 0);
    check("reset_underrun", int'(underrun), 0);
    rst = 1'b0;
    tick();
    stop_found = 1'b1;
    tick();
    check_quiet("idle_ignores_stop");

    for (int t = 0; t < 60; t++) begin
      transfer();
      check("underrun_sticky", int'(underrun), int'(model_unr));
    end
    stop_found = 1'b1;
    tick();
    tick();
    check("load_queue_drained", load_q.size(), 0);
    check("ack_queue_drained", ack_q.size(), 0);

    // Reset in TX of the second byte after one acknowledged empty-FIFO byte.
    start_found = 1'b1;
    tick();
    address_match = 1'b1;
    rw_mode = 1'b1;
    byte_received = 1'b1;
    ack_q.push_back(1);
    tick();
    tick();
    tx_fifo_empty = 1'b1;
    ack_done = 1'b1;
    load_q.push_back('{rd: 1'b0, cnt: 8'd0});
    tick();
    tick();
    byte_received = 1'b1;
    tick();
    sda_in = 1'b0;
    check_ack = 1'b1;
    tick();
    tx_fifo_empty = 1'b0;
    ack_done = 1'b1;
    load_q.push_back('{rd: 1'b1, cnt: 8'd1});
    tick();
    tick();
    check("pre_reset_tx", int'(tx_enable), 1);
    check("pre_reset_bytes", int'(bytes_sent), 1);
    check("pre_reset_underrun", int'(underrun), 1);
    #2 rst = 1'b1;
    #1;
    check_quiet("async_reset_outputs");
    check("async_reset_bytes", int'(bytes_sent), 0);
    check("async_reset_underrun", int'(underrun), 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    tick();
    check_quiet("post_reset_idle");
    check("final_load_queue", load_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
